vga_timing_interface: RTL and testbench

- Generates 640x480 @ 60 Hz VGA timing from the 100 MHz system clock.
- Produces the pixel address that the snake control block consumes, and takes back that block's 12-bit colour.
- Drives the blanked, sync-aligned colour and HS/VS to the board VGA connector.
- Emits a one-cycle frame strobe that the game uses to pace snake movement.

---
 rtl/vga_timing_interface_if.sv | 35 +++
 rtl/vga_timing_interface.sv | 123 ++++++++++++
 tb/tb_vga_timing_interface.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_interface_if.sv
// Pixel bus between the VGA timing generator, its pixel source and the DAC pins.
// The timing generator is the master: it publishes the pixel address and the
// registered colour/sync, and takes the colour back from the source.
interface vga_timing_interface_if;
  logic [11:0] COLOUR_IN;
  logic [9:0]  ADDRH;
  logic [8:0]  ADDRV;
  logic [11:0] COLOUR_OUT;
  logic        HS;
  logic        VS;
  logic        PIX_TICK;
  logic        FRAME_TICK;

  modport master (
    input  COLOUR_IN,
    output ADDRH,
    output ADDRV,
    output COLOUR_OUT,
    output HS,
    output VS,
    output PIX_TICK,
    output FRAME_TICK
  );

  modport slave (
    output COLOUR_IN,
    input  ADDRH,
    input  ADDRV,
    input  COLOUR_OUT,
    input  HS,
    input  VS,
    input  PIX_TICK,
    input  FRAME_TICK
  );
endinterface

// File: rtl/vga_timing_interface.sv
// VGA raster timing generator (640x480 @ 60 Hz at the default geometry).
// A clock divider produces the pixel strobe; horizontal/vertical counters walk
// the raster; colour, HS and VS are registered together one pixel late so they
// stay aligned at the connector. The address seen by the pixel source is the
// undelayed position, forced to 0 outside the visible area.
module vga_timing_interface #(
  parameter int unsigned PIX_DIV = 4,
  parameter int unsigned H_DISP  = 640,
  parameter int unsigned H_FP    = 16,
  parameter int unsigned H_SYNC  = 96,
  parameter int unsigned H_BP    = 48,
  parameter int unsigned V_DISP  = 480,
  parameter int unsigned V_FP    = 10,
  parameter int unsigned V_SYNC  = 2,
  parameter int unsigned V_BP    = 33
) (
  input  logic                   CLK,
  input  logic                   RESET,
  vga_timing_interface_if.master vga_io
);

  localparam int unsigned H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int unsigned DivW    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DivW-1:0] DivLast = DivW'(PIX_DIV - 1);
  localparam logic [9:0] HLast   = 10'(H_TOTAL - 1);
  localparam logic [9:0] VLast   = 10'(V_TOTAL - 1);
  localparam logic [9:0] HDisp   = 10'(H_DISP);
  localparam logic [9:0] VDisp   = 10'(V_DISP);
  localparam logic [9:0] HsFirst = 10'(H_DISP + H_FP);
  localparam logic [9:0] HsLast  = 10'(H_DISP + H_FP + H_SYNC - 1);
  localparam logic [9:0] VsFirst = 10'(V_DISP + V_FP);
  localparam logic [9:0] VsLast  = 10'(V_DISP + V_FP + V_SYNC - 1);

  logic [DivW-1:0] div_q, div_d;
  logic [9:0]      hcount_q, hcount_d;
  logic [9:0]      vcount_q, vcount_d;
  logic [11:0]     colour_q, colour_d;
  logic            hs_q, hs_d;
  logic            vs_q, vs_d;

  logic pix_tick;
  logic h_wrap;
  logic v_wrap;
  logic h_vis;
  logic v_vis;
  logic hs_active;
  logic vs_active;

  // Raster decode of the current (pre-increment) position and the pixel strobe.
  always_comb begin
    // Reset masks the strobe so a reset can never launch a pixel or frame tick.
    pix_tick  = ~RESET & (div_q == DivLast);
    // >= rather than == so a corrupted counter still folds back into range.
    h_wrap    = (hcount_q >= HLast);
    v_wrap    = (vcount_q >= VLast);
    h_vis     = (hcount_q < HDisp);
    v_vis     = (vcount_q < VDisp);
    hs_active = (hcount_q >= HsFirst) && (hcount_q <= HsLast);
    vs_active = (vcount_q >= VsFirst) && (vcount_q <= VsLast);
  end

  // Next state for the divider, raster counters and the aligned output stage.
  always_comb begin
    div_d    = (div_q >= DivLast) ? '0 : div_q + 1'b1;
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    colour_d = colour_q;
    hs_d     = hs_q;
    vs_d     = vs_q;
    if (pix_tick) begin
      hcount_d = h_wrap ? '0 : hcount_q + 10'd1;
      if (h_wrap) begin
        vcount_d = v_wrap ? '0 : vcount_q + 10'd1;
      end
      // Anything the source drives during blanking is discarded here.
      colour_d = (h_vis && v_vis) ? vga_io.COLOUR_IN : 12'h000;
      hs_d     = ~hs_active;
      vs_d     = ~vs_active;
    end
  end

  // State registers; synchronous reset takes priority over every update.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      div_q    <= '0;
      hcount_q <= '0;
      vcount_q <= '0;
      colour_q <= 12'h000;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
    end else begin
      div_q    <= div_d;
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      colour_q <= colour_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
    end
  end

  // Drive the bus: live address for the source, registered pixel for the DAC.
  always_comb begin
    vga_io.ADDRH      = h_vis ? hcount_q : 10'd0;
    vga_io.ADDRV      = v_vis ? vcount_q[8:0] : 9'd0;
    vga_io.COLOUR_OUT = colour_q;
    vga_io.HS         = hs_q;
    vga_io.VS         = vs_q;
    vga_io.PIX_TICK   = pix_tick;
    vga_io.FRAME_TICK = pix_tick & h_wrap & v_wrap;
  end

  // Counters must stay inside the raster whatever the pixel source does.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      a_hcount_range: assert (hcount_q <= HLast);
      a_vcount_range: assert (vcount_q <= VLast);
      a_div_range:    assert (div_q <= DivLast);
    end
  end

endmodule

// File: tb/tb_vga_timing_interface.sv
// Bench for vga_timing_interface: one instance at the real 640x480 geometry for
// reset, line, HS and address/colour timing, and one shrunken instance so whole
// frames, VS, FRAME_TICK and mid-frame reset fit in a short run.
module tb_vga_timing_interface;

  logic clk;
  logic rst_full;
  logic rst_small;
  logic src_fff;
  logic sel;

  int unsigned n_tests;
  int unsigned n_fail;

  vga_timing_interface_if full_if ();
  vga_timing_interface_if small_if ();

  vga_timing_interface u_full (
    .CLK    (clk),
    .RESET  (rst_full),
    .vga_io (full_if)
  );

  // 16 x 10 raster: HS low at h 10..12, VS low at v 7..8, 640 CLK per frame.
  vga_timing_interface #(
    .PIX_DIV (4),
    .H_DISP  (8),
    .H_FP    (2),
    .H_SYNC  (3),
    .H_BP    (3),
    .V_DISP  (6),
    .V_FP    (1),
    .V_SYNC  (2),
    .V_BP    (1)
  ) u_small (
    .CLK    (clk),
    .RESET  (rst_small),
    .vga_io (small_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pixel sources: either constant white or a colour built from the address.
  always_comb begin
    full_if.COLOUR_IN  = src_fff ? 12'hFFF : {full_if.ADDRH[5:2], full_if.ADDRV[5:2], 4'h0};
    small_if.COLOUR_IN = src_fff ? 12'hFFF : {small_if.ADDRH[5:2], small_if.ADDRV[5:2], 4'h0};
  end

  logic [9:0]  s_addrh;
  logic [8:0]  s_addrv;
  logic [11:0] s_col;
  logic        s_hs, s_vs, s_pix, s_frame;

  always_comb begin
    if (sel) begin
      s_addrh = small_if.ADDRH;      s_addrv = small_if.ADDRV;
      s_col   = small_if.COLOUR_OUT; s_hs    = small_if.HS;
      s_vs    = small_if.VS;         s_pix   = small_if.PIX_TICK;
      s_frame = small_if.FRAME_TICK;
    end else begin
      s_addrh = full_if.ADDRH;       s_addrv = full_if.ADDRV;
      s_col   = full_if.COLOUR_OUT;  s_hs    = full_if.HS;
      s_vs    = full_if.VS;          s_pix   = full_if.PIX_TICK;
      s_frame = full_if.FRAME_TICK;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Geometry of the selected instance, written out by hand.
  int unsigned ht, hd, vt, vd, hs_first, hs_last, vs_first, vs_last;

  // Run state
  int unsigned pix_n, cyc, line_cyc, frame_cyc, frame_cnt;
  int unsigned hs_low_cnt, vs_low_cnt, stray_frame;
  int          hs_first_n;
  logic [11:0] prev_col;
  logic        prev_hs, prev_vs;

  task automatic select_dut(input logic s);
    sel = s;
    if (s) begin
      ht = 16;  hd = 8;   vt = 10;  vd = 6;
      hs_first = 10;  hs_last = 12;  vs_first = 7;   vs_last = 8;
    end else begin
      ht = 800; hd = 640; vt = 525; vd = 480;
      hs_first = 656; hs_last = 751; vs_first = 490; vs_last = 491;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_colour"}, s_col, 12'h000);
    check_eq({tag, "_hs"}, s_hs, 1'b1);
    check_eq({tag, "_vs"}, s_vs, 1'b1);
    check_eq({tag, "_addrh"}, s_addrh, 0);
    check_eq({tag, "_addrv"}, s_addrv, 0);
    check_eq({tag, "_frame_tick"}, s_frame, 1'b0);
    check_eq({tag, "_pix_tick"}, s_pix, 1'b0);
  endtask

  // Called just after a negedge; that CLK counts as cycle 1 after release.
  task automatic start_run(input logic s);
    select_dut(s);
    pix_n = 0;  cyc = 1;  line_cyc = 0;  frame_cyc = 0;  frame_cnt = 0;
    hs_low_cnt = 0;  vs_low_cnt = 0;  hs_first_n = -1;
    prev_col = 12'h000;  prev_hs = 1'b1;  prev_vs = 1'b1;
    if (s) rst_small = 1'b0;
    else   rst_full  = 1'b0;
  endtask

  task automatic wait_tick(output bit ok, output int unsigned gap);
    ok  = 1'b0;
    gap = 0;
    while (!ok && gap < 12) begin
      @(negedge clk);
      #1;
      gap++;
      cyc++;
      if (s_pix) ok = 1'b1;
      else if (s_frame) stray_frame++;
    end
  endtask

  // Each pixel tick: outputs must show pixel n-1, address must show pixel n.
  task automatic run_ticks(input int unsigned count);
    bit          ok;
    int unsigned gap, h, v;
    for (int unsigned i = 0; i < count; i++) begin
      wait_tick(ok, gap);
      if (!ok) begin
        check_eq("pix_tick_timeout", 0, 1);
        return;
      end
      h = pix_n % ht;
      v = (pix_n / ht) % vt;
      if (pix_n == 0) check_eq("first_tick_clk", cyc, 4);
      else            check_eq("pix_period", gap, 4);
      check_eq("addrh", s_addrh, (h < hd) ? h : 0);
      check_eq("addrv", s_addrv, (v < vd) ? v : 0);
      check_eq("colour_out", s_col, prev_col);
      check_eq("hs", s_hs, prev_hs);
      check_eq("vs", s_vs, prev_vs);
      check_eq("frame_tick", s_frame, (h == ht - 1) && (v == vt - 1));
      if (pix_n >= 1 && (pix_n - 1) / ht == 1 && !s_hs) hs_low_cnt++;
      if (pix_n >= 1 && (pix_n - 1) < ht * vt && !s_vs) vs_low_cnt++;
      if (!s_hs && hs_first_n < 0) hs_first_n = int'(pix_n);
      if (h == 0) begin
        if (pix_n != 0) check_eq("line_clk", cyc - line_cyc, ht * 4);
        line_cyc = cyc;
      end
      if (s_frame) begin
        if (frame_cnt == 0) check_eq("first_frame_clk", cyc, ht * vt * 4);
        else                check_eq("frame_clk", cyc - frame_cyc, ht * vt * 4);
        frame_cyc = cyc;
        frame_cnt++;
      end
      prev_col = (h < hd && v < vd) ? (src_fff ? 12'hFFF : {h[5:2], v[5:2], 4'h0}) : 12'h000;
      prev_hs  = !(h >= hs_first && h <= hs_last);
      prev_vs  = !(v >= vs_first && v <= vs_last);
      pix_n++;
    end
  endtask

  initial begin
    n_tests = 0;  n_fail = 0;  stray_frame = 0;
    rst_full = 1'b1;  rst_small = 1'b1;  src_fff = 1'b0;
    select_dut(1'b0);

    // Reset held for 5 CLK on both instances
    repeat (5) @(negedge clk);
    #1;
    check_reset_outputs("reset_full");
    select_dut(1'b1);
    #1;
    check_reset_outputs("reset_small");

    // Three full-size lines with the address-derived source
    select_dut(1'b0);
    #1;
    start_run(1'b0);
    run_ticks(2400);
    check_eq("hs_low_ticks", hs_low_cnt, 96);
    check_eq("hs_first_low_tick", hs_first_n, 657);
    check_eq("no_frame_in_lines", frame_cnt, 0);

    // Two small frames: address source, then constant white
    select_dut(1'b1);
    #1;
    start_run(1'b1);
    run_ticks(160);
    src_fff = 1'b1;
    run_ticks(160);
    check_eq("vs_low_ticks", vs_low_cnt, 32);
    check_eq("hs_low_ticks_small", hs_low_cnt, 3);
    check_eq("hs_first_low_small", hs_first_n, 11);
    check_eq("frame_count", frame_cnt, 2);

    // Mid-frame reset at h=5, v=3 while COLOUR_OUT is white
    run_ticks(54);
    check_eq("pre_reset_colour", s_col, 12'hFFF);
    rst_small = 1'b1;
    @(negedge clk);
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    #1;
    check_reset_outputs("mid_reset_hold");
    start_run(1'b1);
    run_ticks(160);
    check_eq("frame_count_after_reset", frame_cnt, 1);
    check_eq("stray_frame_ticks", stray_frame, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
